// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : digit_serial_adder
//  Description : Digit-serial adder. Accepts two NDIG-digit operands of
//                2-bit digits, adds one digit pair per clock (LSB first)
//                with a registered inter-digit carry, then presents the
//                full sum and final carry on a valid/ready output port.
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_adder #(
  parameter int NDIG = 4,
  localparam int W   = 2 * NDIG
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  // Digit counter needs at least one bit even when only one digit exists.
  localparam int            CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [2:0]    digit_sum;
  logic [W-1:0]  sum_shift;

  // Current digit pair plus carry-in; bit 2 is the carry into the next digit.
  assign digit_sum = {1'b0, a_sh[1:0]} + {1'b0, b_sh[1:0]} + {2'b00, carry};

  // New digits enter at the top of the sum register and shift down, so after
  // NDIG steps digit 0 ends up in sum[1:0].
  generate
    if (NDIG == 1) begin : g_sum_single
      assign sum_shift = digit_sum[1:0];
    end else begin : g_sum_multi
      assign sum_shift = {digit_sum[1:0], sum[W-1:2]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, NDIG digit steps in RUN, hold in DONE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid)     state_next = S_RUN;
      S_RUN:   if (cnt == LAST)  state_next = S_DONE;
      S_DONE:  if (out_ready)    state_next = S_IDLE;
      default:                   state_next = S_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE:  in_ready  = 1'b1;
      S_RUN:   busy      = 1'b1;
      S_DONE:  begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: load operands on accept, add and shift one digit per RUN cycle,
  // hold the result in DONE and IDLE until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
          end
        end
        S_RUN: begin
          sum   <= sum_shift;
          carry <= digit_sum[2];
          a_sh  <= a_sh >> 2;
          b_sh  <= b_sh >> 2;
          cnt   <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign cout = carry;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_serial_adder
//  Description : Scoreboard testbench for digit_serial_adder (NDIG=4 and
//                NDIG=1 instances). Stimulus pushes expected results, a
//                monitor pops and compares at each output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_serial_adder;

  localparam int NDIG = 4;
  localparam int W    = 2 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  logic         in_valid1;
  logic         in_ready1;
  logic [1:0]   a1;
  logic [1:0]   b1;
  logic         cin1;
  logic         out_valid1;
  logic         out_ready1;
  logic [1:0]   sum1;
  logic         cout1;
  logic         busy1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc = 0;

  logic [W:0] exp_q[$];
  int         acc_q[$];
  logic       prev_ov = 1'b0;

  digit_serial_adder #(.NDIG(NDIG)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  digit_serial_adder #(.NDIG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: while the result is presented it must match the queued
  // expectation; the entry is retired on the handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_valid with empty scoreboard (cycle %0d)", cyc);
        end else begin
          if (!prev_ov) chk("latency", 32'(cyc), 32'(acc_q[0] + NDIG));
          chk("result", 32'({cout, sum}), 32'(exp_q[0]));
          chk("in_ready_busy_in_done", 32'({in_ready, busy}), 32'b01);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  // Present operands and wait (bounded) for the accept edge. Called just
  // after a rising edge; returns just after the accept edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                      input logic [W:0] ev, input bit keep, input bit chk_space);
    int n = 0;
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 expected 1 after %0d cycles", n);
    end else begin
      exp_q.push_back(ev);
      acc_q.push_back(cyc + 1);
      if (chk_space) chk("accept_spacing", 32'(cyc + 1 - last_acc), 32'(NDIG + 2));
      last_acc = cyc + 1;
    end
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic wait_ov();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         ci;
    int           n;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({in_ready, out_valid, busy, cout, sum}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_outputs", 32'({in_ready, out_valid, busy, cout, sum}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));

    // 1: full carry ripple
    send(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 1'b0);
    drain();

    // 2: held result under backpressure
    out_ready = 1'b0;
    send(8'h5A, 8'h33, 1'b1, 9'h08E, 1'b0, 1'b0);
    wait_ov();
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'({in_ready, out_valid}), 32'b01);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_to_idle", 32'({in_ready, out_valid, busy}), 32'b100);
    chk("held_after_release", 32'({cout, sum}), 32'h08E);

    // 3: asynchronous reset mid-RUN discards the partial result
    send(8'hAA, 8'h55, 1'b0, 9'h0FF, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("mid_run_reset", 32'({in_ready, out_valid, busy, cout, sum}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4: back-to-back with in_valid and out_ready held high
    send(8'h12, 8'h34, 1'b0, 9'h046, 1'b1, 1'b0);
    send(8'hF0, 8'h0F, 1'b1, 9'h100, 1'b1, 1'b1);
    send(8'h80, 8'h80, 1'b1, 9'h101, 1'b0, 1'b1);
    drain();

    // 5: in_valid during RUN and DONE is ignored
    out_ready = 1'b0;
    send(8'h21, 8'h43, 1'b0, 9'h064, 1'b0, 1'b0);
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_ov();
    @(posedge clk); #1;
    a = 8'h77; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    @(posedge clk); #1;
    chk("no_spurious_accept", 32'({in_ready, busy}), 32'b10);

    // 6: single-digit instance
    a1 = 2'b11; b1 = 2'b11; cin1 = 1'b1; in_valid1 = 1'b1;
    @(negedge clk);
    chk("n1_in_ready", 32'(in_ready1), 32'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("n1_run_not_valid", 32'({out_valid1, busy1}), 32'b01);
    @(negedge clk);
    chk("n1_result", 32'({out_valid1, cout1, sum1}), 32'b1111);
    @(posedge clk); #1;
    a1 = 2'b01; b1 = 2'b10; cin1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("n1_result2", 32'({out_valid1, cout1, sum1}), 32'b1011);
    @(posedge clk); #1;

    // 7: random regression with random output stalls
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      ci = 1'($urandom);
      out_ready = 1'($urandom);
      send(av, bv, ci, 9'(av) + 9'(bv) + 9'(ci), 1'b0, 1'b0);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        out_ready = 1'($urandom);
        @(posedge clk); #1;
        n++;
      end
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL random_timeout: txn %0d pending expected drained", i);
        exp_q.delete();
        acc_q.delete();
      end
      if ((i % 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
